// File: rtl/uc_seq.sv
// rtl/uc_seq.sv - multi-cycle control sequencer with zero flag, stack tracking and memory handshake
module uc_seq #(
  parameter  int STACK_DEPTH = 8,
  parameter  int MEM_TIMEOUT = 15,
  parameter  int TOW         = 4,
  localparam int SPW         = $clog2(STACK_DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [5:0]     opcode,
  input  logic           z_alu,
  input  logic           mem_ack,
  output logic           ir_en,
  output logic           pc_en,
  output logic           s_inc,
  output logic           s_pila,
  output logic           we3,
  output logic           wez,
  output logic           we4,
  output logic           push,
  output logic           pop,
  output logic [1:0]     s_inm,
  output logic [2:0]     op_alu,
  output logic           mem_req,
  output logic           z,
  output logic [SPW-1:0] sp,
  output logic           halted,
  output logic           fault,
  output logic           illegal
);

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    EXEC    = 3'd1,
    MEMWAIT = 3'd2,
    HALT    = 3'd3,
    FAULT   = 3'd4
  } state_t;

  localparam logic [SPW-1:0] SP_FULL  = SPW'(STACK_DEPTH);
  localparam logic [TOW-1:0] TO_LIMIT = TOW'(MEM_TIMEOUT);

  state_t         state;
  logic [TOW-1:0] cnt;
  logic           is_store;

  // Outputs are held idle while reset is asserted, even though state already reads FETCH.
  always_comb begin
    ir_en   = 1'b0;
    pc_en   = 1'b0;
    s_inc   = 1'b1;
    s_pila  = 1'b0;
    we3     = 1'b0;
    wez     = 1'b0;
    we4     = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    s_inm   = 2'b00;
    op_alu  = 3'b000;
    mem_req = 1'b0;
    halted  = 1'b0;
    fault   = 1'b0;
    illegal = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: ir_en = 1'b1;
        EXEC: begin
          casez (opcode)
            6'b0?????: begin
              op_alu = opcode[4:2];
              we3    = 1'b1;
              wez    = 1'b1;
              pc_en  = 1'b1;
            end
            6'b100000: begin
              s_inm = 2'b01;
              we3   = 1'b1;
              pc_en = 1'b1;
            end
            6'b100001: begin
              s_inc = 1'b0;
              pc_en = 1'b1;
            end
            6'b100010: begin
              s_inc = ~z;
              pc_en = 1'b1;
            end
            6'b100011: begin
              s_inc = z;
              pc_en = 1'b1;
            end
            6'b100100: begin
              if (sp < SP_FULL) begin
                push  = 1'b1;
                pc_en = 1'b1;
              end
            end
            6'b100101: begin
              if (sp != '0) begin
                pop    = 1'b1;
                s_pila = 1'b1;
                pc_en  = 1'b1;
              end
            end
            6'b111000, 6'b111100, 6'b111111: ;
            default: begin
              illegal = 1'b1;
              pc_en   = 1'b1;
            end
          endcase
        end
        MEMWAIT: begin
          mem_req = 1'b1;
          we4     = is_store;
          if (mem_ack) begin
            pc_en = 1'b1;
            if (!is_store) begin
              we3   = 1'b1;
              s_inm = 2'b10;
            end
          end
        end
        HALT:    halted = 1'b1;
        FAULT:   fault  = 1'b1;
        default: fault  = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      z        <= 1'b0;
      sp       <= '0;
      cnt      <= '0;
      is_store <= 1'b0;
    end else begin
      case (state)
        FETCH: state <= EXEC;
        EXEC: begin
          casez (opcode)
            6'b0?????: begin
              z     <= z_alu;
              state <= FETCH;
            end
            6'b100100: begin
              if (sp < SP_FULL) begin
                sp    <= sp + 1'b1;
                state <= FETCH;
              end else begin
                state <= FAULT;
              end
            end
            6'b100101: begin
              if (sp != '0) begin
                sp    <= sp - 1'b1;
                state <= FETCH;
              end else begin
                state <= FAULT;
              end
            end
            6'b111000, 6'b111100: begin
              cnt      <= '0;
              is_store <= opcode[2];
              state    <= MEMWAIT;
            end
            6'b111111: state <= HALT;
            default:   state <= FETCH;
          endcase
        end
        // An ack arriving on the final timeout cycle still completes the access.
        MEMWAIT: begin
          if (mem_ack)              state <= FETCH;
          else if (cnt == TO_LIMIT) state <= FAULT;
          else                      cnt   <= cnt + 1'b1;
        end
        HALT:    state <= HALT;
        FAULT:   state <= FAULT;
        default: state <= FAULT;
      endcase
    end
  end

endmodule

// File: doc/uc_seq.md
Name: uc_seq

Overview:
Parametrised multi-cycle successor to the single-cycle control unit. It keeps the existing 6-bit opcode map and adds several features: a FETCH/EXEC/MEMWAIT/HALT/FAULT state machine, an internal zero-flag register, an internal stack-depth tracker with overflow/underflow detection, and a req/ack data-memory handshake with timeout. It sits between instruction memory and the datapath (PC mux, register bank, ALU, stack, data memory).

Parameters:
STACK_DEPTH, 8, number of stack entries the datapath stack holds (≥1); SPW = clog2(STACK_DEPTH+1) is derived as a localparam.
MEM_TIMEOUT, 15, maximum cycles MEMWAIT waits for mem_ack before faulting (≥1).
TOW, 4, width of the timeout counter; must satisfy 2^TOW > MEM_TIMEOUT.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
opcode  in  6  instruction opcode from instruction memory, valid from the cycle after ir_en
z_alu  in  1  combinational zero output of the ALU
mem_ack  in  1  data memory completion, single-cycle pulse
ir_en  out  1  latch instruction register
pc_en  out  1  PC register update enable
s_inc  out  1  1 = PC+1, 0 = jump target
s_pila  out  1  1 = PC from stack top
we3  out  1  register bank write enable
wez  out  1  zero-flag update strobe (mirrors internal update)
we4  out  1  data memory write enable
push  out  1  stack push
pop  out  1  stack pop
s_inm  out  2  register write source: 00 ALU, 01 immediate, 10 data memory
op_alu  out  3  ALU operation
mem_req  out  1  data memory request
z  out  1  registered zero flag
sp  out  SPW  current stack occupancy
halted  out  1  in HALT state
fault  out  1  in FAULT state
illegal  out  1  one-cycle pulse on an undefined opcode

Behaviour:
- Reset (async, immediate): state=FETCH, z=0, sp=0, timeout counter=0. All outputs take their idle values: s_inc=1, s_pila=0, s_inm=00, op_alu=000, every enable/strobe 0, halted=0, fault=0, illegal=0.
- Outputs are combinational from state, opcode, z, sp and mem_ack. They take idle values except where listed below.
- FETCH: ir_en=1; next state EXEC.
- EXEC, decoded by opcode:
  - 0xxxxx arithmetic: op_alu=opcode[4:2], we3=1, wez=1, s_inm=00, pc_en=1; z<=z_alu at the clock edge; next FETCH.
  - 100000 load immediate: s_inm=01, we3=1, pc_en=1; next FETCH.
  - 100001 jump: s_inc=0, pc_en=1; next FETCH.
  - 100010 jump if z: s_inc = ~z, pc_en=1. 100011 jump if not z: s_inc = z, pc_en=1. Both use the registered z; next FETCH.
  - 100100 push: if sp<STACK_DEPTH, push=1, pc_en=1, sp+1, next FETCH. If sp==STACK_DEPTH, no strobes, next FAULT.
  - 100101 pop/return: if sp>0, pop=1, s_pila=1, pc_en=1, sp-1, next FETCH. If sp==0, no strobes, next FAULT.
  - 111000 load word, 111100 store word: next MEMWAIT, counter cleared; no strobes in EXEC.
  - 111111 halt: next HALT, pc_en=0.
  - Any other opcode: illegal=1, pc_en=1 (treated as NOP); next FETCH.
- MEMWAIT: mem_req=1 every cycle.
  - Store: we4=1 while waiting.
  - On mem_ack=1: pc_en=1 in the same cycle; for load also we3=1, s_inm=10; next FETCH.
  - Without ack: counter+1. When the counter reaches MEM_TIMEOUT with no ack, next FAULT.
  - An ack on the timeout cycle wins (completes normally).
- HALT: halted=1, all enables 0; the only exit is reset.
- FAULT: fault=1, all enables 0; sticky until reset.
- Only arithmetic updates z; jumps, loads and stack ops leave z unchanged.
- sp never wraps; it saturates only via the FAULT transition.
- mem_ack outside MEMWAIT is ignored.
- Reset asserted mid-MEMWAIT or mid-EXEC aborts immediately; sp, z and the counter clear.

Test Plan:
- Reset, then arithmetic opcode 000100 with z_alu=1 → cycle 1 ir_en=1; cycle 2 op_alu=001, we3=1, wez=1, pc_en=1; z=1 afterwards.
- z=1, opcode 100010 → s_inc=0, pc_en=1. Same with opcode 100011 → s_inc=1.
- STACK_DEPTH=2: three push instructions → sp 1, 2, then fault=1 with push=0 on the third. After reset, a pop with sp=0 → fault=1, pop=0.
- Load word with mem_ack on the 3rd MEMWAIT cycle → mem_req high 3 cycles; in the ack cycle we3=1, s_inm=10, pc_en=1; next ir_en=1.
- Store word with no ack, MEM_TIMEOUT=15 → we4 and mem_req high for 16 cycles, then fault=1. Repeat with ack on the 16th cycle → normal completion.
- Opcode 101010 → illegal pulses 1 cycle, pc_en=1. Opcode 111111 → halted=1 and stays there despite further opcodes. Async reset → halted=0, state FETCH.
